// File: rtl/squ_conv_scheduler.sv
// rtl/squ_conv_scheduler.sv - squeeze-layer request scheduler: walks beat/kernel/column/row,
// issues paired data/kernel consume strobes, then drains the MAC pipeline before signalling done.
module squ_conv_scheduler #(
    parameter int PIPE_LAT = 24
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       start_i,
    input  logic [5:0] beats_per_out_i,
    input  logic [9:0] no_of_squ_kernals_i,
    input  logic [6:0] squ_layer_dimension_i,
    input  logic       squ_data_ready_i,
    input  logic       squ_ker_ready_i,
    input  logic       output_fifo_busy_i,
    output logic       squ_data_req_o,
    output logic       squ_ker_req_o,
    output logic       fifo_squ_bash_clr_o,
    output logic       last_beat_o,
    output logic [9:0] cur_ker_o,
    output logic [6:0] cur_row_o,
    output logic [6:0] cur_col_o,
    output logic       busy_o,
    output logic       done_o
);

    localparam int DW = $clog2(PIPE_LAT + 2);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t        r_state;
    state_t        w_next;
    logic [5:0]    r_n;
    logic [9:0]    r_k;
    logic [6:0]    r_d;
    logic [5:0]    r_beat;
    logic [9:0]    r_ker;
    logic [6:0]    r_col;
    logic [6:0]    r_row;
    logic          r_clr;
    logic [DW-1:0] r_drain;

    logic w_req;
    logic w_start;
    logic w_beat_max;
    logic w_ker_max;
    logic w_col_max;
    logic w_row_max;

    assign w_start    = (r_state == S_IDLE) & start_i;
    assign w_req      = (r_state == S_RUN) & squ_data_ready_i & squ_ker_ready_i & ~output_fifo_busy_i;
    assign w_beat_max = (r_beat == r_n);
    assign w_ker_max  = (r_ker == r_k);
    assign w_col_max  = (r_col == r_d);
    assign w_row_max  = (r_row == r_d);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start_i) w_next = S_RUN;
            S_RUN:   if (w_req & w_beat_max & w_ker_max & w_col_max & w_row_max) w_next = S_DRAIN;
            S_DRAIN: if (r_drain == DW'(PIPE_LAT)) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Config is captured only on an accepted start so it stays stable through RUN/DRAIN.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_n   <= '0;
            r_k   <= '0;
            r_d   <= '0;
            r_clr <= 1'b0;
        end else begin
            r_clr <= w_start;
            if (w_start) begin
                r_n <= beats_per_out_i;
                r_k <= no_of_squ_kernals_i;
                r_d <= squ_layer_dimension_i;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_beat <= '0;
            r_ker  <= '0;
            r_col  <= '0;
            r_row  <= '0;
        end else if (w_start) begin
            r_beat <= '0;
            r_ker  <= '0;
            r_col  <= '0;
            r_row  <= '0;
        end else if (w_req) begin
            r_beat <= w_beat_max ? 6'd0 : r_beat + 6'd1;
            if (w_beat_max) begin
                r_ker <= w_ker_max ? 10'd0 : r_ker + 10'd1;
            end
            if (w_beat_max & w_ker_max) begin
                r_col <= w_col_max ? 7'd0 : r_col + 7'd1;
            end
            if (w_beat_max & w_ker_max & w_col_max) begin
                r_row <= w_row_max ? 7'd0 : r_row + 7'd1;
            end
        end
    end

    // Drain runs free of output_fifo_busy_i; downstream absorbs in-flight results.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_drain <= '0;
        end else if (r_state == S_DRAIN) begin
            r_drain <= r_drain + DW'(1);
        end else begin
            r_drain <= '0;
        end
    end

    assign squ_data_req_o      = w_req;
    assign squ_ker_req_o       = w_req;
    assign fifo_squ_bash_clr_o = r_clr;
    assign last_beat_o         = w_req & w_beat_max;
    assign cur_ker_o           = r_ker;
    assign cur_row_o           = r_row;
    assign cur_col_o           = r_col;
    assign busy_o              = (r_state != S_IDLE);
    assign done_o              = (r_state == S_DONE);

endmodule

// File: doc/squ_conv_scheduler.md
SQU_CONV_SCHEDULER -- requirements
Module: squ_conv_scheduler

Interface
REQ-001 Parameter PIPE_LAT, default 24: drain cycles after the last request, covering the squeeze MAC/adder pipeline plus output packing.
REQ-002 clk_i  in  1  single clock; all logic rises on posedge clk_i.
REQ-003 rst_i  in  1  reset, asynchronous and active-high.
REQ-004 start_i  in  1  one-cycle layer start pulse; honoured only in IDLE.
REQ-005 beats_per_out_i  in  6  (8-channel beats per output value) - 1.
REQ-006 no_of_squ_kernals_i  in  10  (number of squeeze kernels) - 1.
REQ-007 squ_layer_dimension_i  in  7  (layer dimension after max pool) - 1.
REQ-008 squ_data_ready_i  in  1  data source holds a valid 8-wide data beat.
REQ-009 squ_ker_ready_i  in  1  kernel source holds a valid 8-wide kernel beat.
REQ-010 output_fifo_busy_i  in  1  downstream output FIFO cannot accept more.
REQ-011 squ_data_req_o  out  1  data beat consume strobe.
REQ-012 squ_ker_req_o  out  1  kernel beat consume strobe; always equal to squ_data_req_o.
REQ-013 fifo_squ_bash_clr_o  out  1  one-cycle clear pulse to the bias FIFO.
REQ-014 last_beat_o  out  1  high with a request that is the final beat of one output value.
REQ-015 cur_ker_o  out  10  kernel index of the current request.
REQ-016 cur_row_o, cur_col_o  out  7 each  pixel position of the current request.
REQ-017 busy_o  out  1  high in every state except IDLE.
REQ-018 done_o  out  1  one-cycle pulse when the layer completes.

Function
REQ-019 FSM states SHALL be IDLE, RUN, DRAIN, DONE.
REQ-020 IDLE->RUN on start_i. On that edge: latch all three config inputs, clear all counters, and pulse fifo_squ_bash_clr_o in the following cycle.
REQ-021 start_i outside IDLE SHALL be ignored; latched config SHALL stay stable until the next accepted start.
REQ-022 squ_data_req_o = (state==RUN) & squ_data_ready_i & squ_ker_ready_i & ~output_fifo_busy_i. This is combinational from registered state, with zero-cycle response to any ready drop or busy rise.
REQ-023 Each request cycle consumes exactly one beat. Counters advance on the request edge, nested innermost to outermost: beat (0..N), kernel (0..K), column (0..D), row (0..D). Each counter wraps to 0 and carries to the next outer counter.
REQ-024 Total requests per layer SHALL be (N+1)*(K+1)*(D+1)^2, where N, K, D are the latched values. Maximum is 64*1024*128*128, so the design needs 30-bit capacity.
REQ-025 last_beat_o = squ_data_req_o & (beat counter == N).
REQ-026 cur_ker_o, cur_row_o and cur_col_o reflect the counter values of the current request. They hold between requests.
REQ-027 On the request where all four counters are at maximum, RUN->DRAIN. No further request is issued in DRAIN, whatever the inputs.
REQ-028 DRAIN SHALL count PIPE_LAT cycles and then go to DONE. DONE asserts done_o for exactly one cycle and returns to IDLE.
REQ-029 output_fifo_busy_i SHALL NOT stall the DRAIN counter; in-flight results are absorbed downstream.
REQ-030 Zero configuration (N=K=D=0) SHALL be legal: exactly one request with last_beat_o=1, then DRAIN.
REQ-031 A ready or busy change between requests SHALL only gap requests, never skip or repeat a counter value.

Reset
REQ-032 While rst_i=1, regardless of clock: state=IDLE, all counters and latched config = 0.
REQ-033 While rst_i=1, all outputs = 0. squ_data_req_o and squ_ker_req_o are forced low because state is IDLE.
REQ-034 Reset asserted mid-RUN or mid-DRAIN SHALL abort the layer with no done_o pulse. After release the block waits for a new start_i.

Verification
REQ-035 The bench SHALL cover at least the following directed scenarios.
- N=1, K=1, D=1, readies held 1, busy 0 -> 16 consecutive request cycles; last_beat_o on every 2nd request; done_o exactly PIPE_LAT+1 cycles after the last request edge.
- Same config with busy toggling every 3 cycles -> still exactly 16 requests, never while busy=1; counter sequence monotone with no gaps or repeats.
- N=K=D=0 -> one request with last_beat_o=1; fifo_squ_bash_clr_o pulse one cycle after start; done_o pulse; busy_o low afterwards.
- Second start_i mid-RUN with different config -> ignored; request count matches the first config.
- rst_i asserted asynchronously on the 5th request cycle -> squ_data_req_o and busy_o low within the same cycle; no done_o; a new start yields a correct full layer.
- squ_ker_ready_i low while squ_data_ready_i is high -> no request issued; requests resume on the same clock edge that both readies are high.
